fft_seq: RTL and testbench

- Control sequencer for an in-place radix-2 decimation-in-frequency FFT built around the butterfly processor (D=(A+B)/2, E=(A-B)/2·W).
- Per stage, walks all N/2 butterflies and issues operand-memory read addresses (A, B) plus the twiddle-ROM index feeding c/cps/cms.
- Issues write-back addresses delayed by the butterfly pipeline latency.
- Drains the pipeline between stages and runs a start/busy/done handshake with the host.

---
 rtl/fft_seq_pkg.sv | 24 ++
 rtl/fft_seq_if.sv | 33 +++
 rtl/fft_seq_delay_line.sv | 35 +++
 rtl/fft_seq.sv | 126 ++++++++++++
 tb/tb_fft_seq.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/fft_seq_pkg.sv
// Shared definitions for the radix-2 DIF FFT control sequencer: state encoding,
// default sizing and the bit-reversal helper used when unloading results.
package fft_seq_pkg;

  localparam int DEF_LOG2N  = 3;
  localparam int DEF_BF_LAT = 3;
  localparam int N          = 1 << DEF_LOG2N;
  localparam int HALF_N     = N / 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Reverse the low 'bits' bits of x; DIF output lands in bit-reversed order.
  function automatic logic [7:0] bit_rev(input logic [7:0] x, input int bits);
    logic [7:0] r;
    r = {<<{x}};
    return r >> (8 - bits);
  endfunction

endpackage

// File: rtl/fft_seq_if.sv
// Host/memory-side signal bundle of the FFT sequencer.
interface fft_seq_if import fft_seq_pkg::*; #(
  parameter int LOG2N = DEF_LOG2N
) ();

  // start is sampled only while idle; busy stays high from the first read of
  // stage 0 through the last write-back; done pulses for one cycle afterwards.
  logic             start;
  logic             busy;
  logic             done;
  logic [LOG2N-1:0] stage;
  logic             rd_en;
  logic [LOG2N-1:0] rd_addr_a;
  logic [LOG2N-1:0] rd_addr_b;
  logic [LOG2N-2:0] tw_addr;
  logic             wr_en;
  logic [LOG2N-1:0] wr_addr_a;
  logic [LOG2N-1:0] wr_addr_b;
  state_t           dbg_state;

  modport slave (
    input  start,
    output busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
           wr_en, wr_addr_a, wr_addr_b, dbg_state
  );

  modport master (
    output start,
    input  busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
           wr_en, wr_addr_a, wr_addr_b, dbg_state
  );

endinterface

// File: rtl/fft_seq_delay_line.sv
// Valid+data shift register matching the butterfly pipeline latency; the tail
// carries the write-back strobe and addresses.
module fft_seq_delay_line #(
  parameter int DEPTH = 3,
  parameter int W     = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic [DEPTH-1:0] r_valid;
  logic [W-1:0]     r_data [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) r_data[i] <= '0;
    end else begin
      r_valid[0] <= i_valid;
      r_data[0]  <= i_data;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_data[i]  <= r_data[i-1];
      end
    end
  end

  assign o_valid = r_valid[DEPTH-1];
  assign o_data  = r_data[DEPTH-1];

endmodule

// File: rtl/fft_seq.sv
// In-place radix-2 DIF FFT sequencer: per stage it walks N/2 butterflies,
// issues operand/twiddle addresses, then drains the butterfly pipeline.
module fft_seq import fft_seq_pkg::*; #(
  parameter int LOG2N  = DEF_LOG2N,
  parameter int BF_LAT = DEF_BF_LAT
) (
  input  logic      clk,
  input  logic      reset,
  fft_seq_if.slave  io_seq
);

  localparam int               HALF   = 1 << (LOG2N - 1);
  localparam int               CW     = $clog2(BF_LAT + 1);
  localparam logic [LOG2N-2:0] K_LAST = (LOG2N-1)'(HALF - 1);
  localparam logic [LOG2N-1:0] S_LAST = LOG2N'(LOG2N - 1);
  localparam logic [LOG2N-1:0] SPAN0  = LOG2N'(HALF);

  state_t           r_state;
  logic [LOG2N-2:0] r_k;
  logic [LOG2N-1:0] r_s;
  logic [CW-1:0]    r_drain;
  logic             r_busy;
  logic             r_done;
  logic             r_rd_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_s     <= '0;
      r_drain <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rd_en <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (io_seq.start) begin
            r_state <= S_RUN;
            r_k     <= '0;
            r_s     <= '0;
            r_busy  <= 1'b1;
            r_rd_en <= 1'b1;
          end
        end
        S_RUN: begin
          if (r_k == K_LAST) begin
            r_state <= S_DRAIN;
            r_drain <= CW'(BF_LAT);
            r_rd_en <= 1'b0;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        S_DRAIN: begin
          // Next stage reads only after this stage's last write has issued.
          if (r_drain == CW'(1)) begin
            if (r_s == S_LAST) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RUN;
              r_s     <= r_s + 1'b1;
              r_k     <= '0;
              r_rd_en <= 1'b1;
            end
          end else begin
            r_drain <= r_drain - 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // g*2*span + j == 2*(k - j) + j, so no divider is needed.
  logic [LOG2N-1:0] w_span;
  logic [LOG2N-1:0] w_kx;
  logic [LOG2N-1:0] w_j;
  logic [LOG2N-1:0] w_a;
  logic [LOG2N-1:0] w_b;
  logic [LOG2N-2:0] w_tw;

  assign w_span = SPAN0 >> r_s;
  assign w_kx   = {1'b0, r_k};
  assign w_j    = w_kx & (w_span - 1'b1);
  assign w_a    = ((w_kx - w_j) << 1) + w_j;
  assign w_b    = w_a + w_span;
  assign w_tw   = w_j[LOG2N-2:0] << r_s;

  logic [LOG2N-1:0] w_rd_a;
  logic [LOG2N-1:0] w_rd_b;
  logic             w_wr_valid;
  logic [2*LOG2N-1:0] w_wr_data;

  assign w_rd_a = r_rd_en ? w_a : '0;
  assign w_rd_b = r_rd_en ? w_b : '0;

  fft_seq_delay_line #(
    .DEPTH (BF_LAT),
    .W     (2 * LOG2N)
  ) u_delay (
    .clk     (clk),
    .reset   (reset),
    .i_valid (r_rd_en),
    .i_data  ({w_rd_a, w_rd_b}),
    .o_valid (w_wr_valid),
    .o_data  (w_wr_data)
  );

  assign io_seq.busy      = r_busy;
  assign io_seq.done      = r_done;
  assign io_seq.stage     = r_s;
  assign io_seq.rd_en     = r_rd_en;
  assign io_seq.rd_addr_a = w_rd_a;
  assign io_seq.rd_addr_b = w_rd_b;
  assign io_seq.tw_addr   = r_rd_en ? w_tw : '0;
  assign io_seq.wr_en     = w_wr_valid;
  assign io_seq.wr_addr_a = w_wr_data[2*LOG2N-1:LOG2N];
  assign io_seq.wr_addr_b = w_wr_data[LOG2N-1:0];
  assign io_seq.dbg_state = r_state;

endmodule

// File: tb/tb_fft_seq.sv
// Bench for fft_seq: cycle-by-cycle comparison against a timeline model of the
// transform, for an N=8/BF_LAT=3 and an N=16/BF_LAT=5 instance.
module tb_fft_seq;
  import fft_seq_pkg::*;

  typedef struct {
    int busy, done, rd_en, wr_en, stage, ra, rb, tw, wa, wb;
  } obs_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fft_seq_if #(.LOG2N(3)) sif3 ();
  fft_seq_if #(.LOG2N(4)) sif4 ();

  fft_seq #(.LOG2N(3), .BF_LAT(3)) u_dut3 (.clk(clk), .reset(reset), .io_seq(sif3));
  fft_seq #(.LOG2N(4), .BF_LAT(5)) u_dut4 (.clk(clk), .reset(reset), .io_seq(sif4));

  int n_checks = 0;
  int n_bad    = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_start(input int d, input bit v);
    if (d == 3) sif3.start = v;
    else        sif4.start = v;
  endtask

  function automatic obs_t sample(input int d);
    obs_t o;
    if (d == 3) begin
      o.busy = int'(sif3.busy);  o.done = int'(sif3.done);
      o.rd_en = int'(sif3.rd_en); o.wr_en = int'(sif3.wr_en);
      o.stage = int'(sif3.stage); o.ra = int'(sif3.rd_addr_a);
      o.rb = int'(sif3.rd_addr_b); o.tw = int'(sif3.tw_addr);
      o.wa = int'(sif3.wr_addr_a); o.wb = int'(sif3.wr_addr_b);
    end else begin
      o.busy = int'(sif4.busy);  o.done = int'(sif4.done);
      o.rd_en = int'(sif4.rd_en); o.wr_en = int'(sif4.wr_en);
      o.stage = int'(sif4.stage); o.ra = int'(sif4.rd_addr_a);
      o.rb = int'(sif4.rd_addr_b); o.tw = int'(sif4.tw_addr);
      o.wa = int'(sif4.wr_addr_a); o.wb = int'(sif4.wr_addr_b);
    end
    return o;
  endfunction

  // Read issued in cycle c after a start sampled at the end of cycle 0.
  function automatic void rd_model(input int log2n, input int lat, input int c,
                                   output int en, output int a, output int b,
                                   output int tw, output int s);
    int half = 1 << (log2n - 1);
    int per  = half + lat;
    int k, span, j, g;
    en = 0; a = 0; b = 0; tw = 0; s = 0;
    if (c >= 1 && c <= log2n * per) begin
      s = (c - 1) / per;
      k = (c - 1) % per;
      if (k < half) begin
        en   = 1;
        span = (1 << log2n) >> (s + 1);
        j    = k % span;
        g    = k / span;
        a    = g * 2 * span + j;
        b    = a + span;
        tw   = (j << s) % half;
      end
    end
  endfunction

  function automatic obs_t model(input int log2n, input int lat, input int c);
    obs_t e;
    int t2, s2;
    int total = log2n * ((1 << (log2n - 1)) + lat);
    rd_model(log2n, lat, c, e.rd_en, e.ra, e.rb, e.tw, e.stage);
    rd_model(log2n, lat, c - lat, e.wr_en, e.wa, e.wb, t2, s2);
    e.busy = int'(c >= 1 && c <= total);
    e.done = int'(c == total + 1);
    return e;
  endfunction

  task automatic cmp(input int d, input int c, input obs_t o, input obs_t e);
    string p = $sformatf("d%0d c%0d", d, c);
    logic [15:0] x;
    check({p, " busy"}, o.busy, e.busy);
    check({p, " done"}, o.done, e.done);
    check({p, " rd_en"}, o.rd_en, e.rd_en);
    check({p, " wr_en"}, o.wr_en, e.wr_en);
    if (e.busy != 0) check({p, " stage"}, o.stage, e.stage);
    if (e.rd_en != 0) begin
      check({p, " rd_a"}, o.ra, e.ra);
      check({p, " rd_b"}, o.rb, e.rb);
      check({p, " tw"}, o.tw, e.tw);
      exp_q.push_back({8'(e.ra), 8'(e.rb)});
    end
    if (e.wr_en != 0) begin
      check({p, " wr_a"}, o.wa, e.wa);
      check({p, " wr_b"}, o.wb, e.wb);
    end
    if (o.wr_en != 0) begin
      if (exp_q.size() == 0) check({p, " wr_unmatched"}, 1, 0);
      else begin
        x = exp_q.pop_front();
        check({p, " wr_pair"}, int'({8'(o.wa), 8'(o.wb)}), int'(x));
      end
    end
  endtask

  task automatic run_check(input int d, input int hold_len, input int abort_at);
    int log2n = (d == 3) ? 3 : 4;
    int lat   = (d == 3) ? 3 : 5;
    int total = log2n * ((1 << (log2n - 1)) + lat);
    obs_t o, e;
    exp_q.delete();
    @(negedge clk);
    set_start(d, 1'b1);
    for (int c = 1; c <= total + 4; c++) begin
      @(negedge clk);
      if (c == abort_at) begin
        reset = 1'b1;
        #1;
        o = sample(d);
        check("abort busy", o.busy, 0);
        check("abort rd_en", o.rd_en, 0);
        check("abort wr_en", o.wr_en, 0);
        check("abort done", o.done, 0);
        check("abort rd_a", o.ra, 0);
        set_start(d, 1'b0);
        return;
      end
      o = sample(d);
      e = model(log2n, lat, c);
      cmp(d, c, o, e);
      set_start(d, c < hold_len);
    end
    set_start(d, 1'b0);
    check($sformatf("d%0d wr_queue_left", d), exp_q.size(), 0);
  endtask

  task automatic recover();
    obs_t o;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      o = sample(3);
      check("post_abort wr_en", o.wr_en, 0);
      check("post_abort busy", o.busy, 0);
      check("post_abort rd_en", o.rd_en, 0);
    end
  endtask

  initial begin
    obs_t o;
    reset = 1'b1;
    sif3.start = 1'b0;
    sif4.start = 1'b0;
    repeat (2) @(negedge clk);
    o = sample(3);
    check("rst busy", o.busy, 0);
    check("rst done", o.done, 0);
    check("rst rd_en", o.rd_en, 0);
    check("rst wr_en", o.wr_en, 0);
    check("rst stage", o.stage, 0);
    check("rst rd_a", o.ra, 0);
    check("rst rd_b", o.rb, 0);
    check("rst tw", o.tw, 0);
    check("rst wr_a", o.wa, 0);
    check("rst wr_b", o.wb, 0);
    o = sample(4);
    check("rst4 busy", o.busy, 0);
    check("rst4 rd_b", o.rb, 0);
    reset = 1'b0;
    @(negedge clk);

    // Single-cycle start pulse, then start held through busy and DONE.
    run_check(3, 1, 0);
    run_check(3, 23, 0);
    repeat (4) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_check(3, $urandom_range(1, 23), 0);
    end

    // Abort mid stage 1, then a random abort point; each followed by a replay.
    run_check(3, 1, 10);
    recover();
    run_check(3, 1, 0);
    run_check(3, $urandom_range(1, 3), $urandom_range(2, 21));
    recover();
    run_check(3, 1, 0);

    // Larger transform: 8 reads per stage, done 53 cycles after start.
    run_check(4, 1, 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
